// File: rtl/exe_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : exe_mem_stage
// Description : EXE/MEM pipeline boundary of the Strontium 5-stage MIPS core.
//               Registers the EXE-stage results toward writeback. Runs
//               single-word load/store transactions on a req/ack data-memory
//               port, and stalls the upstream stages while one is pending.
//               Misaligned word accesses and ack timeouts are aborted and
//               reported with one-cycle error pulses.
// Ports       : clk, reset (async, active-low), ena (capture enable)
//               exe_*        : EXE-stage instruction fields and ALU result
//               dmem_*       : data-memory req/ack port
//               mem_stall    : freeze upstream while an access is pending
//               mem_GPR_*    : writeback enable/address/data
//               mem_pc_out   : PC of the instruction in MEM
//               mem_addr_err : misaligned access pulse
//               mem_bus_err  : ack timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
module exe_mem_stage #(
    parameter int MAX_WAIT    = 255,  // ack timeout in cycles (1..65535)
    parameter bit ALIGN_CHECK = 1'b1  // reject word accesses with addr[1:0] != 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic [31:0] exe_alu_result_in,
    input  logic [31:0] exe_mem_fetch_addr_in,
    input  logic [31:0] exe_GPR_rt_in,
    input  logic [31:0] exe_pc_in,
    input  logic        exe_GPR_we_in,
    input  logic [4:0]  exe_GPR_waddr_in,
    input  logic [1:0]  exe_GPR_wdata_select_in,
    input  logic [1:0]  exe_mem_op_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_GPR_we,
    output logic [4:0]  mem_GPR_waddr,
    output logic [31:0] mem_GPR_wdata,
    output logic [31:0] mem_pc_out,
    output logic        mem_addr_err,
    output logic        mem_bus_err
);

    localparam logic [1:0]  c_OP_LW     = 2'b01;
    localparam logic [1:0]  c_OP_SW     = 2'b10;
    localparam logic [1:0]  c_SEL_LOAD  = 2'b01;
    localparam logic [1:0]  c_SEL_PC8   = 2'b10;
    localparam logic [15:0] c_LAST_WAIT = 16'(MAX_WAIT - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_wait_cnt;

    // Writeback information held while the memory access is in flight.
    logic        r_cap_we;
    logic        r_cap_sel_load;
    logic [31:0] r_cap_wdata;

    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic        r_gpr_we;
    logic [4:0]  r_gpr_waddr;
    logic [31:0] r_gpr_wdata;
    logic [31:0] r_pc;
    logic        r_addr_err;
    logic        r_bus_err;

    logic        w_is_mem;
    logic        w_misaligned;
    logic [31:0] w_pc_plus8;
    logic [31:0] w_sel_wdata;
    logic        w_timeout;

    assign w_is_mem     = (exe_mem_op_in == c_OP_LW) || (exe_mem_op_in == c_OP_SW);
    assign w_misaligned = ALIGN_CHECK && (exe_mem_fetch_addr_in[1:0] != 2'b00);
    assign w_pc_plus8   = exe_pc_in + 32'd8;
    // Select 01 without a memory op falls back to the ALU result.
    assign w_sel_wdata  = (exe_GPR_wdata_select_in == c_SEL_PC8) ? w_pc_plus8
                                                                  : exe_alu_result_in;
    assign w_timeout    = (r_wait_cnt == c_LAST_WAIT);

    // Combinational so upstream can advance in the ack cycle itself.
    assign mem_stall = (r_state == S_ACCESS) && !dmem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= 16'd0;
            r_cap_we       <= 1'b0;
            r_cap_sel_load <= 1'b0;
            r_cap_wdata    <= 32'd0;
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= 32'd0;
            r_dmem_wdata   <= 32'd0;
            r_gpr_we       <= 1'b0;
            r_gpr_waddr    <= 5'd0;
            r_gpr_wdata    <= 32'd0;
            r_pc           <= 32'd0;
            r_addr_err     <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ena) begin
                        r_pc        <= exe_pc_in;
                        r_gpr_waddr <= exe_GPR_waddr_in;
                        if (!w_is_mem) begin
                            r_gpr_we    <= exe_GPR_we_in;
                            r_gpr_wdata <= w_sel_wdata;
                        end else if (w_misaligned) begin
                            r_gpr_we   <= 1'b0;
                            r_addr_err <= 1'b1;
                        end else begin
                            r_state        <= S_ACCESS;
                            r_wait_cnt     <= 16'd0;
                            r_dmem_req     <= 1'b1;
                            r_dmem_we      <= (exe_mem_op_in == c_OP_SW);
                            r_dmem_addr    <= {exe_mem_fetch_addr_in[31:2], 2'b00};
                            r_dmem_wdata   <= exe_GPR_rt_in;
                            r_gpr_we       <= 1'b0;
                            // A store never writes back.
                            r_cap_we       <= exe_GPR_we_in && (exe_mem_op_in == c_OP_LW);
                            r_cap_sel_load <= (exe_GPR_wdata_select_in == c_SEL_LOAD);
                            r_cap_wdata    <= w_sel_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack) begin
                        r_state     <= S_IDLE;
                        r_wait_cnt  <= 16'd0;
                        r_dmem_req  <= 1'b0;
                        r_gpr_we    <= r_cap_we;
                        r_gpr_wdata <= r_cap_sel_load ? dmem_rdata : r_cap_wdata;
                    end else if (w_timeout) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= 16'd0;
                        r_dmem_req <= 1'b0;
                        r_gpr_we   <= 1'b0;
                        r_bus_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dmem_req      = r_dmem_req;
    assign dmem_we       = r_dmem_we;
    assign dmem_addr     = r_dmem_addr;
    assign dmem_wdata    = r_dmem_wdata;
    assign mem_GPR_we    = r_gpr_we;
    assign mem_GPR_waddr = r_gpr_waddr;
    assign mem_GPR_wdata = r_gpr_wdata;
    assign mem_pc_out    = r_pc;
    assign mem_addr_err  = r_addr_err;
    assign mem_bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
- EXE/MEM pipeline boundary for the Strontium 5-stage MIPS core. Consumes the EXE-stage outputs of the ID/EXE register and the ALU result, and registers them toward writeback.
- Runs single-word load/store transactions on a req/ack data-memory port.
- Drives a stall to the pipeline controller while a transaction is outstanding.

Parameters:
MAX_WAIT, 255, ack timeout in cycles (1..65535); on expiry the access is aborted
ALIGN_CHECK, 1, 1 = reject word accesses with addr[1:0] != 0

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ena  in  1  capture enable from PipelineController
exe_alu_result_in  in  32  ALU result
exe_mem_fetch_addr_in  in  32  effective memory address
exe_GPR_rt_in  in  32  store data
exe_pc_in  in  32  instruction PC
exe_GPR_we_in  in  1  GPR write enable
exe_GPR_waddr_in  in  5  GPR destination
exe_GPR_wdata_select_in  in  2  00 ALU, 01 load data, 10 pc+8, 11 ALU
exe_mem_op_in  in  2  00 none, 01 lw, 10 sw, 11 treated as none
dmem_req  out  1  request valid
dmem_we  out  1  1 = store
dmem_addr  out  32  word address
dmem_wdata  out  32  store data
dmem_ack  in  1  transaction complete (single-cycle pulse)
dmem_rdata  in  32  load data, valid with ack
mem_stall  out  1  freeze upstream stages
mem_GPR_we  out  1  writeback enable
mem_GPR_waddr  out  5  writeback address
mem_GPR_wdata  out  32  writeback data
mem_pc_out  out  32  PC of the instruction in MEM
mem_addr_err  out  1  one-cycle pulse: misaligned access
mem_bus_err  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset (async, active-low): all outputs 0, FSM = IDLE, wait counter = 0. Reset asserted mid-transaction drops dmem_req in the same instant; the pending instruction is discarded.
- FSM states: IDLE, ACCESS.
- IDLE, ena=0: all registered outputs hold their values; error pulses are 0.
- IDLE, ena=1, mem_op none:
  - Next cycle: mem_GPR_we = exe_GPR_we_in, waddr, pc.
  - mem_GPR_wdata = ALU result for select 00/11, exe_pc_in+8 for select 10.
  - Select 01 with no memory op gives wdata = ALU result.
- IDLE, ena=1, mem_op lw/sw, ALIGN_CHECK=1, addr[1:0] != 0:
  - No request is issued.
  - Next cycle: mem_addr_err = 1 for one cycle, mem_GPR_we = 0, pc captured.
- IDLE, ena=1, valid lw/sw:
  - Capture the instruction fields and move to ACCESS.
  - Next cycle: dmem_req = 1, dmem_addr = {addr[31:2], 2'b00}, dmem_we = (op == sw), dmem_wdata = rt.
  - mem_GPR_we = 0 while in ACCESS.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata hold stable until ack. ena is ignored.
  - Wait counter increments once per cycle without ack.
- ACCESS, ack=1:
  - Next cycle: dmem_req = 0, state = IDLE, counter cleared.
  - lw: mem_GPR_we = captured we; mem_GPR_wdata = dmem_rdata if select 01, otherwise the select rule above.
  - sw: mem_GPR_we = 0.
- ACCESS, counter == MAX_WAIT-1 with no ack:
  - Next cycle: dmem_req = 0, IDLE, mem_bus_err = 1 for one cycle, mem_GPR_we = 0.
  - A late ack arriving in IDLE is ignored.
- mem_stall is combinational: (state == ACCESS) & ~dmem_ack. It is therefore 0 in the ack cycle, so upstream may advance and this block captures in the cycle after ack.
- Back-to-back accesses: a new lw/sw captured in the first IDLE cycle after ack raises dmem_req again one cycle later. Minimum of 1 cycle with req=0 between transactions.
- ack while dmem_req = 0 is ignored.
- Arithmetic: pc+8 is modulo 2^32 (0xFFFFFFFC+8 = 0x00000004).

Test Plan:
- ALU op: ena=1, op=00, result=0x12345678, we=1, waddr=5, sel=00 -> next cycle mem_GPR_we=1, waddr=5, wdata=0x12345678, mem_stall=0.
- Load with 3-cycle memory: ena=1, op=01, addr=0x100, sel=01; ack with rdata=0xDEADBEEF on the 3rd req cycle -> req=1, addr=0x100, we=0 for 3 cycles; mem_stall=1 for 2 cycles then 0; the following cycle gives mem_GPR_we=1, wdata=0xDEADBEEF, req=0.
- Store: op=10, addr=0x204, rt=0xCAFEF00D, ack on 1st cycle -> one req cycle with we=1, wdata=0xCAFEF00D; mem_GPR_we stays 0; no stall cycle.
- Misaligned load: op=01, addr=0x102 -> no req, mem_addr_err pulses 1 cycle, mem_GPR_we=0.
- Timeout with MAX_WAIT=4: load, ack never asserted -> req high exactly 4 cycles, then req=0, mem_bus_err 1-cycle pulse, mem_GPR_we=0; a later ack produces no change.
- Reset mid-access: reset low during the 2nd req cycle -> dmem_req, mem_stall and all outputs go 0 immediately; after release, an ALU op (sel=10, pc=0xFFFFFFFC) gives wdata=0x00000004.
